// File: rtl/load_down_counter_pkg.sv
// load_down_counter_pkg: shared state encoding and default width for the down-counter
package load_down_counter_pkg;
    localparam int CNT_WIDTH = 4;
    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
endpackage

// File: rtl/load_down_counter_if.sv
// load_down_counter_if: load handshake, run control and status bundle of the down-counter
interface load_down_counter_if import load_down_counter_pkg::*; #(parameter int WIDTH = CNT_WIDTH) ();
    logic             load_valid_i;
    logic             load_ready_o;
    logic [WIDTH-1:0] load_val_i;
    logic             start_i;
    logic             stop_i;
    logic             auto_reload_i;
    logic [WIDTH-1:0] count_o;
    logic             busy_o;
    logic             done_o;
    logic             tc_o;
    modport master (
        output load_valid_i, load_val_i, start_i, stop_i, auto_reload_i,
        input  load_ready_o, count_o, busy_o, done_o, tc_o
    );
    modport slave (
        input  load_valid_i, load_val_i, start_i, stop_i, auto_reload_i,
        output load_ready_o, count_o, busy_o, done_o, tc_o
    );
endinterface

// File: rtl/load_down_counter_tick_gen.sv
// tick_gen: prescaler emitting one tick every PRESCALE_DIV cycles; exists only with LOAD_DOWN_COUNTER_PRESCALE_EN
`ifdef LOAD_DOWN_COUNTER_PRESCALE_EN
module tick_gen #(
    parameter int PRESCALE_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick
);
    localparam int CW = $clog2(PRESCALE_DIV);
    logic [CW-1:0] r_cnt;
    assign o_tick = r_cnt == CW'(PRESCALE_DIV - 1);
    // free-running divider, restarted on clear so the first tick is a full period away
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_cnt <= '0;
        else        r_cnt <= (i_clear || o_tick) ? '0 : r_cnt + CW'(1);
    end
endmodule
`endif

// File: rtl/load_down_counter.sv
// load_down_counter: loadable down-counter/interval timer with one-shot or auto-reload; LOAD_DOWN_COUNTER_PRESCALE_EN adds a tick prescaler
module load_down_counter import load_down_counter_pkg::*; #(
    parameter int WIDTH        = CNT_WIDTH,
    parameter int PRESCALE_DIV = 4
) (
    input logic                clk,
    input logic                reset,
    load_down_counter_if.slave bus
);
    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_count, w_count_nx;
    logic [WIDTH-1:0] r_reload, w_reload_nx;
    logic             r_tc, w_tc_nx;
    logic             w_tick, w_load_acc, w_go, w_start_acc;

    assign bus.load_ready_o = r_state != RUN;
    assign bus.busy_o       = r_state == RUN;
    assign bus.done_o       = r_state == DONE;
    assign bus.count_o      = r_count;
    assign bus.tc_o         = r_tc;

    assign w_load_acc  = bus.load_valid_i && bus.load_ready_o;
    assign w_go        = bus.start_i && !bus.stop_i && !w_load_acc;
    assign w_start_acc = w_go && (r_state == ARMED || (r_state == DONE && r_reload != '0));

`ifdef LOAD_DOWN_COUNTER_PRESCALE_EN
    tick_gen #(.PRESCALE_DIV(PRESCALE_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_start_acc),
        .o_tick  (w_tick)
    );
`else
    localparam bit unused_prescale_div = PRESCALE_DIV >= 2;
    assign w_tick = 1'b1;
`endif

    // next state: load beats start, stop beats counting, terminal count reloads or finishes
    always_comb begin
        w_state_nx  = r_state;
        w_count_nx  = r_count;
        w_reload_nx = r_reload;
        w_tc_nx     = 1'b0;
        if (w_load_acc) begin
            w_reload_nx = bus.load_val_i;
            w_count_nx  = bus.load_val_i;
            w_state_nx  = (bus.load_val_i != '0) ? ARMED : IDLE;
        end else if (w_start_acc) begin
            w_state_nx = RUN;
            w_count_nx = (r_state == DONE) ? r_reload : r_count;
        end else if (r_state == RUN && bus.stop_i) begin
            w_state_nx = ARMED;
        end else if (r_state == RUN && w_tick) begin
            if (r_count > WIDTH'(1)) begin
                w_count_nx = r_count - WIDTH'(1);
            end else begin
                w_tc_nx    = 1'b1;
                w_count_nx = bus.auto_reload_i ? r_reload : '0;
                w_state_nx = bus.auto_reload_i ? RUN : DONE;
            end
        end
    end

    // state and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_count  <= w_count_nx;
            r_reload <= w_reload_nx;
            r_tc     <= w_tc_nx;
        end
    end
endmodule

// File: tb/tb_load_down_counter.sv
// tb_load_down_counter: directed vectors feed a scoreboard queue; a negedge monitor pops and compares
module tb_load_down_counter;
    import load_down_counter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;
    logic [7:0] sb[$];

    load_down_counter_if #(.WIDTH(4)) bus ();

    load_down_counter #(.WIDTH(4), .PRESCALE_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_vec(input state_t s, input int tc, input int c);
        return {s != RUN, s == RUN, s == DONE, tc != 0, 4'(c)};
    endfunction

    task automatic cyc(input int lv, input int val, input int st, input int sp, input int ar,
                       input state_t s, input int tc, input int c);
        bus.load_valid_i  = lv != 0;
        bus.load_val_i    = 4'(val);
        bus.start_i       = st != 0;
        bus.stop_i        = sp != 0;
        bus.auto_reload_i = ar != 0;
        @(posedge clk);
        #1;
        sb.push_back(exp_vec(s, tc, c));
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            logic [7:0] e, g;
            e = sb.pop_front();
            g = {bus.load_ready_o, bus.busy_o, bus.done_o, bus.tc_o, bus.count_o};
            n_checks++;
            if (g !== e) begin
                n_fails++;
                $display("FAIL outputs check %0d at %0t: got rdy,busy,done,tc,cnt=%b required %b",
                         n_checks, $time, g, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load_valid_i  = 1'b0;
        bus.load_val_i    = '0;
        bus.start_i       = 1'b0;
        bus.stop_i        = 1'b0;
        bus.auto_reload_i = 1'b0;
        #1;
        sb.push_back(exp_vec(IDLE, 0, 0));
        @(posedge clk);
        #1;
        reset = 1'b1;
`ifndef LOAD_DOWN_COUNTER_PRESCALE_EN
        // one-shot of 5
        cyc(1, 5, 0, 0, 0, ARMED, 0, 5);
        cyc(0, 0, 1, 0, 0, RUN,   0, 5);
        cyc(0, 0, 0, 0, 0, RUN,   0, 4);
        cyc(0, 0, 0, 0, 0, RUN,   0, 3);
        cyc(0, 0, 0, 0, 0, RUN,   0, 2);
        cyc(0, 0, 0, 0, 0, RUN,   0, 1);
        cyc(0, 0, 0, 0, 0, DONE,  1, 0);
        cyc(0, 0, 0, 0, 0, DONE,  0, 0);
        // load and start together in DONE: load wins, no decrement
        cyc(1, 2, 1, 0, 0, ARMED, 0, 2);
        cyc(0, 0, 1, 0, 0, RUN,   0, 2);
        cyc(0, 0, 0, 0, 0, RUN,   0, 1);
        cyc(0, 0, 0, 0, 0, DONE,  1, 0);
        // one-shot of 4, then restart from DONE
        cyc(1, 4, 0, 0, 0, ARMED, 0, 4);
        cyc(0, 0, 1, 0, 0, RUN,   0, 4);
        cyc(0, 0, 0, 0, 0, RUN,   0, 3);
        cyc(0, 0, 0, 0, 0, RUN,   0, 2);
        cyc(0, 0, 0, 0, 0, RUN,   0, 1);
        cyc(0, 0, 0, 0, 0, DONE,  1, 0);
        cyc(0, 0, 0, 0, 0, DONE,  0, 0);
        cyc(0, 0, 1, 0, 0, RUN,   0, 4);
        cyc(0, 0, 0, 0, 0, RUN,   0, 3);
        cyc(0, 0, 0, 1, 0, ARMED, 0, 3);
        // auto-reload of 3, with a load of 9 offered during RUN
        cyc(1, 3, 0, 0, 1, ARMED, 0, 3);
        cyc(0, 0, 1, 0, 1, RUN,   0, 3);
        cyc(1, 9, 0, 0, 1, RUN,   0, 2);
        cyc(1, 9, 0, 0, 1, RUN,   0, 1);
        cyc(0, 0, 0, 0, 1, RUN,   1, 3);
        cyc(0, 0, 0, 0, 1, RUN,   0, 2);
        cyc(0, 0, 0, 0, 1, RUN,   0, 1);
        cyc(0, 0, 0, 0, 1, RUN,   1, 3);
        cyc(0, 0, 0, 1, 0, ARMED, 0, 3);
        // pause and resume of 6, start+stop stays armed
        cyc(1, 6, 0, 0, 0, ARMED, 0, 6);
        cyc(0, 0, 1, 0, 0, RUN,   0, 6);
        cyc(0, 0, 0, 0, 0, RUN,   0, 5);
        cyc(0, 0, 0, 0, 0, RUN,   0, 4);
        cyc(0, 0, 0, 1, 0, ARMED, 0, 4);
        cyc(0, 0, 1, 1, 0, ARMED, 0, 4);
        cyc(0, 0, 1, 0, 0, RUN,   0, 4);
        cyc(0, 0, 0, 0, 0, RUN,   0, 3);
        cyc(0, 0, 0, 0, 0, RUN,   0, 2);
        cyc(0, 0, 0, 0, 0, RUN,   0, 1);
        cyc(0, 0, 0, 0, 0, DONE,  1, 0);
        // zero load goes idle, start ignored
        cyc(1, 0, 0, 0, 0, IDLE,  0, 0);
        cyc(0, 0, 1, 0, 0, IDLE,  0, 0);
        cyc(0, 0, 1, 0, 0, IDLE,  0, 0);
        // asynchronous reset while running from 7
        cyc(1, 7, 0, 0, 0, ARMED, 0, 7);
        cyc(0, 0, 1, 0, 0, RUN,   0, 7);
        @(posedge clk);
        #2;
        reset = 1'b0;
        bus.start_i = 1'b0;
        sb.push_back(exp_vec(IDLE, 0, 0));
        @(posedge clk);
        #1;
        sb.push_back(exp_vec(IDLE, 0, 0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(0, 0, 1, 0, 0, IDLE,  0, 0);
`else
        // prescaled run of 2 with PRESCALE_DIV 4: terminal count 8 cycles after start
        cyc(1, 2, 0, 0, 0, ARMED, 0, 2);
        cyc(0, 0, 1, 0, 0, RUN,   0, 2);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, RUN, 0, 2);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, RUN, 0, 1);
        cyc(0, 0, 0, 0, 0, DONE,  1, 0);
        cyc(0, 0, 0, 0, 0, DONE,  0, 0);
`endif
        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard drain: got %0d pending entries required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/load_down_counter.md
Name: load_down_counter

Overview:
- Loadable down-counter / interval timer; the counting-down counterpart of the team's loadable up-counter.
- Accepts a reload value through a valid/ready handshake and counts it down to zero on start.
- Pulses terminal count, then either stops in DONE or auto-reloads from the last loaded value.
- Used as a timeout/interval source beside the up-counter in the same designs.

Parameters:
- WIDTH, 4, counter and reload value width in bits.
- PRESCALE_DIV, 4, clock cycles per decrement tick; used only when PRESCALE_EN is defined; must be >= 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_valid_i  input  1  a reload value is offered.
- load_ready_o  output  1  the block can accept a load.
- load_val_i  input  WIDTH  the reload value.
- start_i  input  1  begin or resume counting (level sampled each edge).
- stop_i  input  1  pause counting.
- auto_reload_i  input  1  at terminal count, reload and keep running instead of stopping.
- count_o  output  WIDTH  current count (registered).
- busy_o  output  1  state is RUN.
- done_o  output  1  state is DONE.
- tc_o  output  1  one-cycle registered terminal-count pulse.

Behaviour:
- States: IDLE, ARMED, RUN, DONE.
- Registers: count_q, reload_q, tc_q, state.
- Reset (reset low, asynchronous):
  - state = IDLE; count_q = 0; reload_q = 0; tc_q = 0.
  - Outputs: load_ready_o = 1, busy_o = 0, done_o = 0, tc_o = 0, count_o = 0.
- Output decode:
  - load_ready_o = (state != RUN), combinational from state.
  - busy_o = (state == RUN).
  - done_o = (state == DONE).
- Load accept = load_valid_i && load_ready_o. On accept:
  - reload_q <= load_val_i; count_q <= load_val_i.
  - Next state = ARMED if load_val_i != 0, else IDLE.
- Load while RUN: not accepted; ready is low, so the value is dropped and the source must hold valid.
- Priority in IDLE, ARMED and DONE: load beats start in the same cycle. Start is ignored that cycle.
- IDLE: start_i is ignored, since there is nothing to count.
- ARMED: start_i = 1 and stop_i = 0 -> RUN. count_q is held.
- DONE: start_i = 1, stop_i = 0 and reload_q != 0 -> count_q <= reload_q, RUN. This restarts from the last loaded value.
- RUN, evaluated on each tick (every cycle without PRESCALE_EN):
  - stop_i = 1 -> ARMED, count_q held, no decrement. stop beats start.
  - count_q > 1 -> count_q <= count_q - 1.
  - count_q == 1 -> tc_q <= 1 for exactly one cycle. Then:
    - auto_reload_i = 1: count_q <= reload_q, stay RUN.
    - auto_reload_i = 0: count_q <= 0, go to DONE.
- Latency:
  - Start sampled at edge k; first decrement at edge k+1.
  - With reload N, tc_o is high in the cycle following edge k+N.
  - Auto-reload period is exactly N cycles, and count_o never shows 0 while auto-reloading.
- Arithmetic: unsigned, no underflow. count_q never wraps below 0.
- auto_reload_i is sampled only at the terminal-count edge.
- Reset mid-RUN: immediate return to the reset values above. reload_q is also cleared.

Optional Feature:
- Macro: LOAD_DOWN_COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler generates a tick once every PRESCALE_DIV cycles.
  - RUN decrements and terminal count occur only on ticks; stop_i still acts on any cycle.
  - The prescaler clears on every start acceptance, so the first tick lands PRESCALE_DIV cycles after start.
  - tc_o remains one clk cycle wide.
- Undefined: tick is a constant 1, no prescaler logic exists, and PRESCALE_DIV is ignored.

Decomposition:
- Shared package load_down_counter_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, ARMED, RUN, DONE};
  - the default width constant CNT_WIDTH = 4.
- Sub-module tick_gen (prescaler, PRESCALE_DIV parameter, clear input, tick output) is natural.
  - It is instantiated only under LOAD_DOWN_COUNTER_PRESCALE_EN.
- All other logic stays in load_down_counter.

Test Plan:
- Reset: drive reset low mid-RUN (count 7) -> count_o = 0, state IDLE, load_ready_o = 1 immediately, asynchronously, and all outputs at reset values.
- One-shot: load 5, start for one cycle with auto_reload_i = 0:
  - count_o sequence 5, 4, 3, 2, 1, 0.
  - tc_o is one pulse, 5 cycles after start.
  - done_o = 1 afterwards.
- Auto-reload: load 3 with auto_reload_i = 1 and start:
  - count_o sequence 3, 2, 1, 3, 2, 1, ...
  - tc_o pulses every 3 cycles and busy_o stays 1.
- Pause/resume and priority:
  - load 6, start, stop after 2 decrements -> count_o holds 4, load_ready_o = 1.
  - start plus stop together -> stays ARMED.
  - start alone -> resumes 3, 2, ...
- Handshake and load priority:
  - load_valid_i with 9 during RUN -> not accepted, reload unchanged.
  - In DONE, load 2 and start in the same cycle -> count_o = 2, state ARMED, no decrement.
- Zero and restart:
  - load 0 -> IDLE; start ignored, tc_o never pulses.
  - After a one-shot of 4 finishes, start in DONE -> count restarts at 4.
  - With PRESCALE_EN and PRESCALE_DIV = 4, load 2 -> tc_o 8 cycles after start.
